// File: rtl/debug_pio_pkg.sv
// Shared constants for the debug PIO blocks: register addresses and
// edge-type encodings used by the input-capture port.
package debug_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/debug_pio_sync.sv
// Multi-stage flop synchronizer for the asynchronous PIO inputs,
// cleared by the synchronous block reset.
module debug_pio_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stage <= '{default: '0};
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/debug_pio_in_capture.sv
// Avalon-MM input PIO with sticky edge capture and maskable irq.
// Build option: DEBUG_PIO_BIT_CLEAR_EN makes EDGE writes write-1-to-clear.
module debug_pio_in_capture
    import debug_pio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    localparam int CW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] WARM_LOAD = CW'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] w_sync_q;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clear;
    logic [WIDTH-1:0] w_rd_mux;
    logic             w_rd;
    logic             w_wr;
    logic             w_armed;

    logic [WIDTH-1:0] r_prev_q;
    logic [WIDTH-1:0] r_capture;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_readdata;
    logic [CW-1:0]    r_warm;

    debug_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (in_port),
        .o_q     (w_sync_q)
    );

    assign w_rd    = chipselect && !read_n;
    assign w_wr    = chipselect && !write_n;
    assign w_armed = (r_warm == '0);

    always_comb begin
        w_edge = w_sync_q & ~r_prev_q;
        if (EDGE_TYPE == EDGE_FALL) begin
            w_edge = ~w_sync_q & r_prev_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            w_edge = w_sync_q ^ r_prev_q;
        end
    end

    always_comb begin
        w_clear = '0;
        if (w_wr && address == PIO_ADDR_EDGE) begin
`ifdef DEBUG_PIO_BIT_CLEAR_EN
            w_clear = writedata;
`else
            w_clear = '1;
`endif
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            PIO_ADDR_DATA: w_rd_mux = w_sync_q;
            PIO_ADDR_MASK: w_rd_mux = r_mask;
            PIO_ADDR_EDGE: w_rd_mux = r_capture;
            default:       w_rd_mux = '0;
        endcase
    end

    // New edges are OR-ed in after the clear so a coincident event survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_q   <= '0;
            r_capture  <= '0;
            r_mask     <= RESET_MASK;
            r_readdata <= '0;
            r_warm     <= WARM_LOAD;
        end else begin
            r_prev_q  <= w_sync_q;
            r_capture <= (r_capture & ~w_clear) | (w_edge & {WIDTH{w_armed}});
            if (!w_armed) begin
                r_warm <= r_warm - 1'b1;
            end
            if (w_wr && address == PIO_ADDR_MASK) begin
                r_mask <= writedata;
            end
            if (w_rd) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_capture & r_mask);

endmodule

// File: tb/tb_debug_pio_in_capture.sv
// Directed bench for debug_pio_in_capture: a default (rising) instance
// plus a falling-edge instance sharing the bus.
module tb_debug_pio_in_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] in_port;
    logic [31:0] in_f;
    logic [31:0] readdata;
    logic [31:0] readdata_f;
    logic        irq;
    logic        irq_f;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debug_pio_in_capture dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    debug_pio_in_capture #(.EDGE_TYPE(1)) dut_f (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_f),
        .readdata   (readdata_f),
        .irq        (irq_f)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic bus_rd(input logic [1:0] a);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        step();
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        reset = 1'b1; address = 2'd0; chipselect = 1'b0;
        read_n = 1'b1; write_n = 1'b1; writedata = '0;
        in_port = 32'hFFFF_FFFF; in_f = '0;
        step(3);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        step(6);
        chk("warm_irq", {31'b0, irq}, 32'h0);
        bus_rd(2'd3);
        chk("warm_edge", readdata, 32'h0);
        bus_rd(2'd2);
        chk("rst_mask", readdata, 32'h0);

        // falling transitions on the rising instance capture nothing
        in_port = 32'h0;
        step(5);
        bus_rd(2'd3);
        chk("fall_ignored", readdata, 32'h0);

        bus_wr(2'd2, 32'h20);
        in_port = 32'h20;
        step();
        chk("lat_e0_irq", {31'b0, irq}, 32'h0);
        step();
        chk("lat_e1_irq", {31'b0, irq}, 32'h0);
        step();
        chk("lat_e2_irq", {31'b0, irq}, 32'h1);
        bus_rd(2'd3);
        chk("bit5_edge", readdata, 32'h20);

        in_port = 32'h30;
        step(4);
        bus_rd(2'd3);
        chk("edge_30", readdata, 32'h30);
        bus_wr(2'd3, 32'h10);
        bus_rd(2'd3);
`ifdef DEBUG_PIO_BIT_CLEAR_EN
        chk("w1c_edge", readdata, 32'h20);
        chk("w1c_irq", {31'b0, irq}, 32'h1);
`else
        chk("clr_edge", readdata, 32'h0);
        chk("clr_irq", {31'b0, irq}, 32'h0);
`endif

        // clear coinciding with a new rising edge on bit 0
        bus_wr(2'd2, 32'h1);
        bus_wr(2'd3, 32'hFFFF_FFFF);
        chk("pre_setwin_irq", {31'b0, irq}, 32'h0);
        in_port = 32'h31;
        step(2);
        bus_wr(2'd3, 32'hFFFF_FFFF);
        chk("setwin_irq", {31'b0, irq}, 32'h1);
        step();
        chk("setwin_irq_hold", {31'b0, irq}, 32'h1);
        bus_rd(2'd3);
        chk("setwin_edge", readdata, 32'h1);

        in_port = 32'hA5A5_A5A5;
        step(3);
        bus_rd(2'd0);
        chk("data_rd", readdata, 32'hA5A5_A5A5);
        bus_wr(2'd1, 32'hDEAD_BEEF);
        bus_rd(2'd1);
        chk("addr1_rd", readdata, 32'h0);
        bus_wr(2'd0, 32'h1234_5678);
        bus_rd(2'd0);
        chk("data_ro", readdata, 32'hA5A5_A5A5);

        // simultaneous read and write of MASK returns the old value
        address = 2'd2; writedata = 32'h55; chipselect = 1'b1;
        read_n = 1'b0; write_n = 1'b0;
        step();
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        chk("rw_old_mask", readdata, 32'h1);
        bus_rd(2'd2);
        chk("rw_new_mask", readdata, 32'h55);

        // falling-edge instance
        bus_wr(2'd3, 32'hFFFF_FFFF);
        in_f = 32'h8;
        step(4);
        bus_rd(2'd3);
        chk("f_rise_ignored", readdata_f, 32'h0);
        in_f = 32'h0;
        step(3);
        bus_rd(2'd3);
        chk("f_fall_edge", readdata_f, 32'h8);
        chk("f_irq_masked", {31'b0, irq_f}, 32'h0);
        bus_wr(2'd2, 32'h8);
        chk("f_irq_unmasked", {31'b0, irq_f}, 32'h1);

        // mid-operation reset drops captures and restarts warm-up
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        chk("mid_rst_rd", readdata, 32'h0);
        step(6);
        bus_rd(2'd3);
        chk("mid_rst_edge", readdata, 32'h0);
        bus_rd(2'd2);
        chk("mid_rst_mask", readdata, 32'h0);
        chk("mid_rst_f_irq", {31'b0, irq_f}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
